// File: rtl/cga_mac_segpt_bank.sv
// Segment / page-table control bank: one PCR per interrupt level, segment
// register with zero flag, XPT/PEX/VEX, and a sequenced clear-all engine.
module cga_mac_segpt_bank #(
  parameter int unsigned LEVELS = 16,
  parameter int unsigned SEG_W  = 8
) (
  input  logic             MCLK,
  input  logic             RESETN,
  input  logic [15:0]      FIDBO_15_0,
  input  logic             LLDPCR,
  input  logic             LLDSEG,
  input  logic             LLDEXM,
  input  logic             EXMN,
  input  logic [3:0]       PIL,
  input  logic             CLRALL,
  output logic [15:0]      PCR_15_7_2_0,
  output logic [3:0]       PCR_14_13_10_9_N,
  output logic [SEG_W-1:0] SEG_7_0,
  output logic             SEGZN,
  output logic [1:0]       XPT_1_0,
  output logic             PEX,
  output logic             VEX,
  output logic             BUSY
);

  localparam int unsigned LVL_W = $clog2(LEVELS);
  localparam int unsigned ENT_W = 12;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   cidx_q, cidx_d;
  logic               busy_q, busy_d;
  logic [ENT_W-1:0]   pcr_q [LEVELS];
  logic [ENT_W-1:0]   pcr_d [LEVELS];
  logic [ENT_W-1:0]   out_q, out_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               segzn_q, segzn_d;
  logic [1:0]         xpt_q, xpt_d;
  logic               pex_q, pex_d;
  logic               vex_q, vex_d;

  logic [3:0]         widx;
  logic               wr_ok;
  logic               clr_act;
  logic [ENT_W-1:0]   wdata;

  assign widx  = FIDBO_15_0[6:3];
  assign wdata = {FIDBO_15_0[15:7], FIDBO_15_0[2:0]};

  // Next-state: FSM, PCR bank updates, output select with write/clear bypass
  always_comb begin
    state_d = state_q;
    cidx_d  = cidx_q;
    busy_d  = busy_q;
    pcr_d   = pcr_q;
    out_d   = '0;
    seg_d   = seg_q;
    xpt_d   = xpt_q;
    pex_d   = pex_q;
    vex_d   = vex_q;
    wr_ok   = 1'b0;
    clr_act = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CLRALL) begin
          state_d = ST_CLEAR;
          cidx_d  = '0;
          busy_d  = 1'b1;
        end else begin
          // Index bits above the bank size must be zero, otherwise the write is dropped
          wr_ok = LLDPCR && (32'(widx) < LEVELS);
        end
      end
      ST_CLEAR: begin
        clr_act = 1'b1;
        cidx_d  = cidx_q + LVL_W'(1);
        if (cidx_q == LVL_W'(LEVELS - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int unsigned i = 0; i < LEVELS; i++) begin
      if (wr_ok && (widx == 4'(i))) pcr_d[i] = wdata;
      if (clr_act && (cidx_q == LVL_W'(i))) pcr_d[i] = '0;
    end

    for (int unsigned i = 0; i < LEVELS; i++) begin
      if (PIL == 4'(i)) out_d = pcr_d[i];
    end

    if (LLDSEG) seg_d = FIDBO_15_0[SEG_W-1:0];
    segzn_d = |seg_d;

    if (LLDEXM) begin
      xpt_d = FIDBO_15_0[1:0];
      pex_d = FIDBO_15_0[2];
      vex_d = ~EXMN;
    end
  end

  // All state advances on the falling edge of MCLK
  always_ff @(negedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      cidx_q  <= '0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < LEVELS; i++) pcr_q[i] <= '0;
      out_q   <= '0;
      seg_q   <= '0;
      segzn_q <= 1'b0;
      xpt_q   <= '0;
      pex_q   <= 1'b0;
      vex_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cidx_q  <= cidx_d;
      busy_q  <= busy_d;
      pcr_q   <= pcr_d;
      out_q   <= out_d;
      seg_q   <= seg_d;
      segzn_q <= segzn_d;
      xpt_q   <= xpt_d;
      pex_q   <= pex_d;
      vex_q   <= vex_d;
    end
  end

  assign PCR_15_7_2_0     = {out_q[11:3], 4'b0000, out_q[2:0]};
  assign PCR_14_13_10_9_N = ~{out_q[10], out_q[9], out_q[6], out_q[5]};
  assign SEG_7_0          = seg_q;
  assign SEGZN            = segzn_q;
  assign XPT_1_0          = xpt_q;
  assign PEX              = pex_q;
  assign VEX              = vex_q;
  assign BUSY             = busy_q;

endmodule

// File: tb/tb_cga_mac_segpt_bank.sv
// Scoreboard bench for cga_mac_segpt_bank (16-level main instance, 4-level side instance).
module tb_cga_mac_segpt_bank;

  logic        MCLK;
  logic        RESETN;
  logic [15:0] FIDBO_15_0;
  logic        LLDPCR, LLDSEG, LLDEXM, EXMN, CLRALL;
  logic [3:0]  PIL;

  logic [15:0] PCR_15_7_2_0;
  logic [3:0]  PCR_14_13_10_9_N;
  logic [7:0]  SEG_7_0;
  logic        SEGZN, PEX, VEX, BUSY;
  logic [1:0]  XPT_1_0;

  logic [15:0] p4_pcr;
  logic [3:0]  p4_pcrn;
  logic [3:0]  p4_seg;
  logic        p4_segzn, p4_pex, p4_vex, p4_busy;
  logic [1:0]  p4_xpt;

  cga_mac_segpt_bank u_dut (
    .MCLK(MCLK), .RESETN(RESETN), .FIDBO_15_0(FIDBO_15_0),
    .LLDPCR(LLDPCR), .LLDSEG(LLDSEG), .LLDEXM(LLDEXM), .EXMN(EXMN),
    .PIL(PIL), .CLRALL(CLRALL),
    .PCR_15_7_2_0(PCR_15_7_2_0), .PCR_14_13_10_9_N(PCR_14_13_10_9_N),
    .SEG_7_0(SEG_7_0), .SEGZN(SEGZN), .XPT_1_0(XPT_1_0),
    .PEX(PEX), .VEX(VEX), .BUSY(BUSY)
  );

  cga_mac_segpt_bank #(.LEVELS(4), .SEG_W(4)) u_dut4 (
    .MCLK(MCLK), .RESETN(RESETN), .FIDBO_15_0(FIDBO_15_0),
    .LLDPCR(LLDPCR), .LLDSEG(LLDSEG), .LLDEXM(LLDEXM), .EXMN(EXMN),
    .PIL(PIL), .CLRALL(CLRALL),
    .PCR_15_7_2_0(p4_pcr), .PCR_14_13_10_9_N(p4_pcrn),
    .SEG_7_0(p4_seg), .SEGZN(p4_segzn), .XPT_1_0(p4_xpt),
    .PEX(p4_pex), .VEX(p4_vex), .BUSY(p4_busy)
  );

  typedef struct packed {
    logic [15:0] pcr;
    logic [3:0]  pcrn;
    logic [7:0]  seg;
    logic        segzn;
    logic [1:0]  xpt;
    logic        pex;
    logic        vex;
    logic        busy;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;

  // Reference model state (16 levels)
  logic [15:0] m_pcr [16];
  logic [7:0]  m_seg;
  logic [1:0]  m_xpt;
  logic        m_pex, m_vex, m_busy;
  int          m_cidx;

  initial MCLK = 1'b1;
  always #5 MCLK = ~MCLK;

  function automatic exp_t obs();
    return {PCR_15_7_2_0, PCR_14_13_10_9_N, SEG_7_0, SEGZN, XPT_1_0, PEX, VEX, BUSY};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pcr[i] = 16'h0000;
    m_seg = 8'h00; m_xpt = 2'b00; m_pex = 1'b0; m_vex = 1'b0;
    m_busy = 1'b0; m_cidx = 0;
  endtask

  // Apply current inputs to the model, queue the expectation, advance one falling edge
  task automatic step();
    exp_t x;
    if (!m_busy) begin
      if (CLRALL) begin
        m_busy = 1'b1;
        m_cidx = 0;
      end else if (LLDPCR) begin
        m_pcr[FIDBO_15_0[6:3]] = FIDBO_15_0 & 16'hFF87;
      end
    end else begin
      m_pcr[m_cidx] = 16'h0000;
      if (m_cidx == 15) m_busy = 1'b0;
      m_cidx = (m_cidx + 1) % 16;
    end
    if (LLDSEG) m_seg = FIDBO_15_0[7:0];
    if (LLDEXM) begin
      m_xpt = FIDBO_15_0[1:0];
      m_pex = FIDBO_15_0[2];
      m_vex = ~EXMN;
    end
    x.pcr   = m_pcr[PIL];
    x.pcrn  = ~{x.pcr[14], x.pcr[13], x.pcr[10], x.pcr[9]};
    x.seg   = m_seg;
    x.segzn = (m_seg != 8'h00);
    x.xpt   = m_xpt;
    x.pex   = m_pex;
    x.vex   = m_vex;
    x.busy  = m_busy;
    sb.push_back(x);
    @(negedge MCLK);
    #1;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; FIDBO_15_0 = 16'h0000; LLDPCR = 1'b0; LLDSEG = 1'b0;
    LLDEXM = 1'b0; EXMN = 1'b1; PIL = 4'd0; CLRALL = 1'b0;
    #1;
    checks++;
    if (obs() !== exp_t'({16'h0000, 4'hF, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0})) begin
      errors++; $display("FAIL reset_state: got %h required %h", obs(),
        exp_t'({16'h0000, 4'hF, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}));
    end
    checks++;
    if ({p4_pcr, p4_pcrn, p4_seg, p4_segzn, p4_xpt, p4_pex, p4_vex, p4_busy} !== {16'h0000, 4'hF, 4'h0, 6'b0}) begin
      errors++; $display("FAIL reset_state_l4: got %h/%h/%h/%b/%b/%b/%b/%b required 0000/f/0/0/00/0/0/0",
        p4_pcr, p4_pcrn, p4_seg, p4_segzn, p4_xpt, p4_pex, p4_vex, p4_busy);
    end
    @(negedge MCLK); #1;
    RESETN = 1'b1;
    model_reset();
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset_idle: got %h required %h", obs(), e); end
    end
  endtask

  task automatic test_pcr_write();
    FIDBO_15_0 = 16'hFFAF; LLDPCR = 1'b1; PIL = 4'd5;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL pcr_write: got %h required %h", obs(), e); end
    checks++;
    if (PCR_15_7_2_0 !== 16'hFF87 || PCR_14_13_10_9_N !== 4'h0) begin
      errors++; $display("FAIL pcr_write_lvl5: got %h/%h required ff87/0", PCR_15_7_2_0, PCR_14_13_10_9_N);
    end
    LLDPCR = 1'b0; PIL = 4'd3;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e || PCR_15_7_2_0 !== 16'h0000) begin
      errors++; $display("FAIL pil_switch: got %h required %h", obs(), e);
    end
    PIL = 4'd5;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL pil_back: got %h required %h", obs(), e); end
  endtask

  task automatic test_bypass();
    PIL = 4'd7; FIDBO_15_0 = 16'h803D; LLDPCR = 1'b1;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e || PCR_15_7_2_0 !== 16'h8005) begin
      errors++; $display("FAIL bypass: got %h required %h", obs(), e);
    end
    checks++;
    if (p4_pcr !== 16'h0000 || p4_pcrn !== 4'hF) begin
      errors++; $display("FAIL l4_pil_range: got %h/%h required 0000/f", p4_pcr, p4_pcrn);
    end
    LLDPCR = 1'b0; PIL = 4'd3;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL bypass_pil3: got %h required %h", obs(), e); end
    checks++;
    if (p4_pcr !== 16'h0000) begin
      errors++; $display("FAIL l4_high_index_drop: got %h required 0000", p4_pcr);
    end
    FIDBO_15_0 = 16'h801D; LLDPCR = 1'b1;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e || p4_pcr !== 16'h8005) begin
      errors++; $display("FAIL l4_write: got %h l4 %h required %h l4 8005", obs(), p4_pcr, e);
    end
    LLDPCR = 1'b0;
  endtask

  task automatic test_seg_exm();
    FIDBO_15_0 = 16'h1200; LLDSEG = 1'b1;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e || SEG_7_0 !== 8'h00 || SEGZN !== 1'b0) begin
      errors++; $display("FAIL seg_zero: got %h required %h", obs(), e);
    end
    FIDBO_15_0 = 16'h0042;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e || SEG_7_0 !== 8'h42 || SEGZN !== 1'b1) begin
      errors++; $display("FAIL seg_42: got %h required %h", obs(), e);
    end
    checks++;
    if (p4_seg !== 4'h2 || p4_segzn !== 1'b1) begin
      errors++; $display("FAIL l4_seg: got %h/%b required 2/1", p4_seg, p4_segzn);
    end
    LLDSEG = 1'b0; FIDBO_15_0 = 16'h0006; LLDEXM = 1'b1; EXMN = 1'b0;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e || XPT_1_0 !== 2'b10 || PEX !== 1'b1 || VEX !== 1'b1) begin
      errors++; $display("FAIL exm_load: got %h required %h", obs(), e);
    end
    FIDBO_15_0 = 16'hA5F9; LLDSEG = 1'b1; LLDPCR = 1'b1; EXMN = 1'b1; PIL = 4'd15;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL all_strobes: got %h required %h", obs(), e); end
    LLDSEG = 1'b0; LLDEXM = 1'b0; LLDPCR = 1'b0;
  endtask

  task automatic fill_bank(input logic [3:0] tag);
    LLDPCR = 1'b1;
    for (int i = 0; i < 16; i++) begin
      FIDBO_15_0 = {tag, 4'(i), 1'b1, 4'(i), 3'b101};
      PIL = 4'(i);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL fill_%0d: got %h required %h", i, obs(), e); end
    end
    LLDPCR = 1'b0;
  endtask

  task automatic test_clear_all();
    int busy_hi;
    fill_bank(4'hC);
    busy_hi = 0;
    CLRALL = 1'b1; PIL = 4'd9;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e || BUSY !== 1'b1) begin errors++; $display("FAIL clr_start: got %h required %h", obs(), e); end
    if (BUSY === 1'b1) busy_hi++;
    CLRALL = 1'b0;
    for (int k = 0; k < 17; k++) begin
      PIL        = (k % 2 == 0) ? 4'(k) : 4'(k + 1);
      LLDPCR     = (k == 3);
      FIDBO_15_0 = 16'h7F97;
      CLRALL     = (k == 5);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL clr_edge_%0d: got %h required %h", k, obs(), e); end
      if (BUSY === 1'b1) busy_hi++;
    end
    LLDPCR = 1'b0; CLRALL = 1'b0;
    checks++;
    if (busy_hi !== 16) begin errors++; $display("FAIL busy_len: got %0d required 16", busy_hi); end
    for (int i = 0; i < 16; i++) begin
      PIL = 4'(i);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL clr_read_%0d: got %h required %h", i, obs(), e); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_hi;
    int budget;
    fill_bank(4'h3);
    FIDBO_15_0 = 16'h6025; LLDPCR = 1'b1; CLRALL = 1'b1; PIL = 4'd4;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL clr_beats_write: got %h required %h", obs(), e); end
    LLDPCR = 1'b0; CLRALL = 1'b0; PIL = 4'd10;
    for (int k = 0; k < 5; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL mid_clr_%0d: got %h required %h", k, obs(), e); end
    end
    RESETN = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || PCR_15_7_2_0 !== 16'h0000 || PCR_14_13_10_9_N !== 4'hF) begin
      errors++; $display("FAIL reset_mid_clr: got busy %b pcr %h n %h required 0/0000/f",
        BUSY, PCR_15_7_2_0, PCR_14_13_10_9_N);
    end
    @(negedge MCLK); #1;
    RESETN = 1'b1;
    model_reset();
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      PIL = 4'(i);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL post_rst_read_%0d: got %h required %h", i, obs(), e); end
    end
    busy_hi = 0;
    budget  = 0;
    CLRALL  = 1'b1;
    PIL     = 4'd0;
    step();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reclr_start: got %h required %h", obs(), e); end
    CLRALL = 1'b0;
    while (BUSY === 1'b1 && budget < 40) begin
      busy_hi++;
      budget++;
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL reclr_edge_%0d: got %h required %h", budget, obs(), e); end
    end
    checks++;
    if (busy_hi !== 16) begin errors++; $display("FAIL reclr_len: got %0d required 16", busy_hi); end
  endtask

  initial begin
    test_reset();
    test_pcr_write();
    test_bypass();
    test_seg_exm();
    test_clear_all();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
